// File: rtl/rf_mv_seq.sv
// ---------------------------------------------------------------------------
// rf_mv_seq
//
// Multi-line move sequencer for the RF move engine. One block-move command
// (src, dst, line count) from the NPU master becomes a series of single-line
// move requests to the engine. The sequencer waits for the engine's done level
// after each request. The copy order gives memmove semantics. When the
// destination overlaps the source from above, the copy starts at the highest
// line and walks down, so no source line is overwritten before it is read.
//
// Parameters
//   ADDR_W  RF line address width; all address arithmetic wraps modulo 2**ADDR_W
//   LINE_W  width of the line-count field
//
// Ports
//   clk          in   1       system clock, rising edge
//   rst_n        in   1       asynchronous active-low reset
//   cmd_valid    in   1       command present
//   cmd_ready    out  1       command can be accepted (high only in IDLE)
//   cmd_src      in   ADDR_W  first source line
//   cmd_dst      in   ADDR_W  first destination line
//   cmd_lines    in   LINE_W  number of lines to move; 0 = no-op
//   cmd_done     out  1       one-cycle pulse when the command completes
//   busy         out  1       high from the cycle after accept through cmd_done
//   mv_start     out  1       one-cycle start pulse to the move engine
//   mv_src_addr  out  ADDR_W  source line of the current move (registered)
//   mv_dst_addr  out  ADDR_W  destination line of the current move (registered)
//   mv_line_num  out  8       lines per engine request, always 1
//   mv_done      in   1       engine done level, cleared the cycle after mv_start
// ---------------------------------------------------------------------------
module rf_mv_seq #(
    parameter int ADDR_W = 9,
    parameter int LINE_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_src,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [LINE_W-1:0] cmd_lines,
    output logic              cmd_done,
    output logic              busy,
    output logic              mv_start,
    output logic [ADDR_W-1:0] mv_src_addr,
    output logic [ADDR_W-1:0] mv_dst_addr,
    output logic [7:0]        mv_line_num,
    input  logic              mv_done
);

    // The overlap test runs one bit wider than the widest operand so that
    // src + lines never wraps. A range that wraps past the top of the RF is
    // therefore treated as non-overlapping and is copied ascending.
    localparam int CMP_W = ((ADDR_W > LINE_W) ? ADDR_W : LINE_W) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_GUARD,
        S_WAIT,
        S_FIN
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [LINE_W-1:0] remaining;
    logic              descending;

    logic              accept;
    logic              line_done;
    logic              cmd_desc;
    logic [CMP_W-1:0]  src_ext;
    logic [CMP_W-1:0]  dst_ext;
    logic [CMP_W-1:0]  lines_ext;
    logic [CMP_W-1:0]  src_end_ext;
    logic [ADDR_W-1:0] lines_addr;
    logic [ADDR_W-1:0] src_last;
    logic [ADDR_W-1:0] dst_last;

    // -----------------------------------------------------------------------
    // Command decode: direction and start addresses
    // -----------------------------------------------------------------------
    assign accept      = cmd_valid & cmd_ready;

    assign src_ext     = CMP_W'(cmd_src);
    assign dst_ext     = CMP_W'(cmd_dst);
    assign lines_ext   = CMP_W'(cmd_lines);
    assign src_end_ext = src_ext + lines_ext;

    // Copying down is needed only when dst lands inside (src, src+lines).
    // dst == src and disjoint ranges are both safe to copy upward.
    assign cmd_desc    = (dst_ext > src_ext) && (dst_ext < src_end_ext);

    // Highest line of each range. This value is only used when lines > 0.
    assign lines_addr  = ADDR_W'(cmd_lines);
    assign src_last    = cmd_src + lines_addr - ADDR_W'(1);
    assign dst_last    = cmd_dst + lines_addr - ADDR_W'(1);

    // A line completes when the engine reports done while we are in WAIT.
    // Any mv_done seen earlier is the previous line's stale level.
    assign line_done   = (state == S_WAIT) && mv_done;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and control outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        cmd_done  = 1'b0;
        busy      = 1'b1;
        mv_start  = 1'b0;

        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    state_nxt = (cmd_lines == '0) ? S_FIN : S_ISSUE;
                end
            end

            S_ISSUE: begin
                mv_start  = 1'b1;
                state_nxt = S_GUARD;
            end

            // The engine drops mv_done only after it has seen mv_start.
            // Spend one cycle here so that a level still high from the
            // previous line is not taken as completion of this one.
            S_GUARD: begin
                state_nxt = S_WAIT;
            end

            S_WAIT: begin
                if (mv_done) begin
                    state_nxt = (remaining == LINE_W'(1)) ? S_FIN : S_ISSUE;
                end
            end

            S_FIN: begin
                cmd_done  = 1'b1;
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Address and line-count registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_addr   <= '0;
            dst_addr   <= '0;
            remaining  <= '0;
            descending <= 1'b0;
        end else if (accept) begin
            remaining  <= cmd_lines;
            descending <= cmd_desc;
            src_addr   <= cmd_desc ? src_last : cmd_src;
            dst_addr   <= cmd_desc ? dst_last : cmd_dst;
        end else if (line_done) begin
            remaining  <= remaining - LINE_W'(1);
            // Both pointers move together, and each wraps around the RF.
            if (descending) begin
                src_addr <= src_addr - ADDR_W'(1);
                dst_addr <= dst_addr - ADDR_W'(1);
            end else begin
                src_addr <= src_addr + ADDR_W'(1);
                dst_addr <= dst_addr + ADDR_W'(1);
            end
        end
    end

    assign mv_src_addr = src_addr;
    assign mv_dst_addr = dst_addr;
    assign mv_line_num = 8'd1;

endmodule

// File: tb/tb_rf_mv_seq.sv
// ---------------------------------------------------------------------------
// tb_rf_mv_seq
//
// Directed bench for rf_mv_seq. A behavioural move engine owns a 512-line RF
// model. It drives mv_done and performs each single-line copy when the
// request finishes. Expected (src, dst) pairs are queued as each command is
// issued. They are popped and compared whenever the sequencer pulses mv_start.
// ---------------------------------------------------------------------------
module tb_rf_mv_seq;

    localparam int ADDR_W = 9;
    localparam int LINE_W = 8;
    localparam int RF_N   = 1 << ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] s;
        logic [ADDR_W-1:0] d;
    } pair_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_src = '0;
    logic [ADDR_W-1:0] cmd_dst = '0;
    logic [LINE_W-1:0] cmd_lines = '0;
    logic              cmd_done;
    logic              busy;
    logic              mv_start;
    logic [ADDR_W-1:0] mv_src_addr;
    logic [ADDR_W-1:0] mv_dst_addr;
    logic [7:0]        mv_line_num;
    logic              mv_done = 1'b0;

    int    checks = 0;
    int    passes = 0;
    int    start_cnt = 0;
    int    done_cnt = 0;
    pair_t exp_q[$];

    logic [7:0]        rf [RF_N];
    logic [7:0]        snap [RF_N];

    int                eng_phase = 0;
    int                eng_cnt = 0;
    int                eng_lat = 1;
    logic [ADDR_W-1:0] eng_s = '0;
    logic [ADDR_W-1:0] eng_d = '0;
    time               last_done_rise = 0;
    time               last_start = 0;
    bit                have_last = 1'b0;

    rf_mv_seq #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_src     (cmd_src),
        .cmd_dst     (cmd_dst),
        .cmd_lines   (cmd_lines),
        .cmd_done    (cmd_done),
        .busy        (busy),
        .mv_start    (mv_start),
        .mv_src_addr (mv_src_addr),
        .mv_dst_addr (mv_dst_addr),
        .mv_line_num (mv_line_num),
        .mv_done     (mv_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    endtask

    task automatic push(input int s, input int d);
        pair_t p;
        p.s = ADDR_W'(s);
        p.d = ADDR_W'(d);
        exp_q.push_back(p);
    endtask

    // Move engine model: it clears done in the cycle after the request, waits
    // eng_lat more cycles, then copies the line and raises done.
    always @(negedge clk) begin
        if (eng_phase == 1) begin
            mv_done   = 1'b0;
            eng_cnt   = eng_lat;
            eng_phase = 2;
        end else if (eng_phase == 2) begin
            if (eng_cnt == 0) begin
                rf[eng_d]      = rf[eng_s];
                mv_done        = 1'b1;
                last_done_rise = $time;
                eng_phase      = 0;
            end else begin
                eng_cnt--;
            end
        end
        if (mv_start) begin
            eng_s     = mv_src_addr;
            eng_d     = mv_dst_addr;
            eng_phase = 1;
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (mv_start) begin
                pair_t p;
                start_cnt++;
                chk("mv_start_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    p = exp_q.pop_front();
                    chk("mv_src_addr", 32'(mv_src_addr), 32'(p.s));
                    chk("mv_dst_addr", 32'(mv_dst_addr), 32'(p.d));
                end
                chk("mv_line_num", 32'(mv_line_num), 1);
                if (have_last) chk("start_spacing_ge3", 32'(($time - last_start) >= 30), 1);
                last_start = $time;
                have_last  = 1'b1;
            end
            if (cmd_done) done_cnt++;
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 1);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_mv_start"}, 32'(mv_start), 0);
        chk({tag, "_cmd_done"}, 32'(cmd_done), 0);
        chk({tag, "_mv_src"}, 32'(mv_src_addr), 0);
        chk({tag, "_mv_dst"}, 32'(mv_dst_addr), 0);
        chk({tag, "_mv_line_num"}, 32'(mv_line_num), 1);
    endtask

    // Present a command and hold it until accepted. The task returns at the
    // first negedge after the accepting posedge.
    task automatic issue_cmd(input int s, input int d, input int n);
        int k;
        @(negedge clk);
        cmd_src   = ADDR_W'(s);
        cmd_dst   = ADDR_W'(d);
        cmd_lines = LINE_W'(n);
        cmd_valid = 1'b1;
        k = 0;
        while (!cmd_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("cmd_ready_before_accept", 32'(cmd_ready), 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("busy_after_accept", 32'(busy), 1);
        chk("ready_low_after_accept", 32'(cmd_ready), 0);
        if (n != 0) begin
            chk("first_start_lat1", 32'(mv_start), 1);
            chk("no_early_done", 32'(cmd_done), 0);
        end else begin
            chk("zero_lines_done_lat1", 32'(cmd_done), 1);
            chk("zero_lines_no_start", 32'(mv_start), 0);
        end
    endtask

    task automatic wait_done(input int n);
        int k;
        k = 0;
        while (!cmd_done && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("cmd_done_seen", 32'(cmd_done), 1);
        chk("busy_at_done", 32'(busy), 1);
        if (n != 0) chk("done_1cyc_after_mv_done", 32'($time - last_done_rise), 10);
        @(negedge clk);
        chk("done_one_cycle", 32'(cmd_done), 0);
        chk("ready_after_done", 32'(cmd_ready), 1);
        chk("idle_not_busy", 32'(busy), 0);
        #1;
        chk("all_pairs_issued", 32'(exp_q.size()), 0);
    endtask

    initial begin
        int s0;
        int d0;
        int k;

        for (int i = 0; i < RF_N; i++) rf[i] = 8'(i * 7 + 3);

        // Reset state
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Test 1: plain ascending copy
        push(10, 100); push(11, 101); push(12, 102);
        s0 = start_cnt; d0 = done_cnt; eng_lat = 1;
        issue_cmd(10, 100, 3);
        wait_done(3);
        chk("t1_starts", 32'(start_cnt - s0), 3);
        chk("t1_dones", 32'(done_cnt - d0), 1);

        // Test 2: overlapping copy with dst above src, done from the top down
        for (int i = 0; i < RF_N; i++) snap[i] = rf[i];
        for (int i = 0; i < 4; i++) snap[22 + i] = rf[20 + i];
        push(23, 25); push(22, 24); push(21, 23); push(20, 22);
        s0 = start_cnt; eng_lat = 2;
        issue_cmd(20, 22, 4);
        wait_done(4);
        chk("t2_starts", 32'(start_cnt - s0), 4);
        for (int i = 20; i < 26; i++) chk($sformatf("t2_rf_%0d", i), 32'(rf[i]), 32'(snap[i]));

        // Test 3: source range wraps past the top of the RF
        push(510, 0); push(511, 1); push(0, 2); push(1, 3);
        s0 = start_cnt; eng_lat = 0;
        issue_cmd(510, 0, 4);
        wait_done(4);
        chk("t3_starts", 32'(start_cnt - s0), 4);

        // Test 4: zero-line command
        s0 = start_cnt; d0 = done_cnt;
        issue_cmd(5, 7, 0);
        wait_done(0);
        chk("t4_no_starts", 32'(start_cnt - s0), 0);
        chk("t4_dones", 32'(done_cnt - d0), 1);

        // Test 5: mv_done is still high from test 3 when this command starts
        push(300, 200); push(301, 201); push(302, 202);
        s0 = start_cnt; eng_lat = 0;
        issue_cmd(300, 200, 3);
        wait_done(3);
        chk("t5_starts", 32'(start_cnt - s0), 3);

        // Overlap boundaries: dst at the last source line (descending), and
        // dst just past the source range (ascending)
        push(43, 46); push(42, 45); push(41, 44); push(40, 43);
        issue_cmd(40, 43, 4);
        wait_done(4);
        push(60, 64); push(61, 65); push(62, 66); push(63, 67);
        issue_cmd(60, 64, 4);
        wait_done(4);

        // Test 6: reset arrives after the second mv_start of a 5-line command
        for (int i = 0; i < 5; i++) push(100 + i, 200 + i);
        s0 = start_cnt; d0 = done_cnt; eng_lat = 1;
        issue_cmd(100, 200, 5);
        #1;
        k = 0;
        while ((start_cnt - s0) < 2 && k < 100) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("t6_two_starts_before_reset", 32'(start_cnt - s0), 2);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        have_last = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        chk("t6_no_done_after_reset", 32'(done_cnt - d0), 0);
        chk("t6_no_more_starts", 32'(start_cnt - s0), 2);
        chk("t6_idle_ready", 32'(cmd_ready), 1);

        // A new command after reset: dst = src+1 is an overlap, so it runs descending
        push(8, 9); push(7, 8);
        s0 = start_cnt; d0 = done_cnt;
        issue_cmd(7, 8, 2);
        wait_done(2);
        chk("t6_new_starts", 32'(start_cnt - s0), 2);
        chk("t6_new_dones", 32'(done_cnt - d0), 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
